// File: rtl/blink_pkg.sv
// Shared types and default widths for the LED blink sequencer.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  localparam int DUR_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: free-running 0..CLK_TICKS-1 counter, o_tick on the last count.
// i_clear restarts the phase so the first tick lands CLK_TICKS cycles later.
module tick_gen #(
  parameter int CLK_TICKS = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/blink_sequencer.sv
// LED blink burst sequencer: count blinks of programmable on/off tick lengths.
// Optional abort input is built when BLINK_SEQ_ABORT_EN is defined.
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int CLK_TICKS = 1000,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DUR_W-1:0] i_on_ticks,
  input  logic [DUR_W-1:0] i_off_ticks,
  input  logic [CNT_W-1:0] i_count,
`ifdef BLINK_SEQ_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_led
);

  // Handshake: i_start is a one-cycle request honoured only while o_busy is
  // low; o_busy stays high for the whole burst and o_done pulses once as it falls.

  blink_state_t state, state_nxt;
  logic [DUR_W-1:0] on_lat, on_nxt, off_lat, off_nxt;
  logic [DUR_W-1:0] dur_cnt, dur_nxt, dur_inc;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic led, led_nxt, busy, busy_nxt, done, done_nxt;
  logic tick, clear;

  tick_gen #(.CLK_TICKS(CLK_TICKS)) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (clear),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      on_lat  <= '0;
      off_lat <= '0;
      dur_cnt <= '0;
      rem     <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      on_lat  <= on_nxt;
      off_lat <= off_nxt;
      dur_cnt <= dur_nxt;
      rem     <= rem_nxt;
      led     <= led_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    on_nxt    = on_lat;
    off_nxt   = off_lat;
    dur_nxt   = dur_cnt;
    rem_nxt   = rem;
    led_nxt   = led;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    clear     = 1'b0;
    dur_inc   = dur_cnt + 1'b1;

    case (state)
      IDLE: begin
        led_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (i_start) begin
          clear = 1'b1;
          if (i_count != '0) begin
            // Zero durations are stored as one tick so the equality compare always terminates.
            on_nxt    = (i_on_ticks == '0) ? DUR_W'(1) : i_on_ticks;
            off_nxt   = (i_off_ticks == '0) ? DUR_W'(1) : i_off_ticks;
            rem_nxt   = i_count;
            dur_nxt   = '0;
            state_nxt = ON;
            led_nxt   = 1'b1;
            busy_nxt  = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ON: begin
        if (tick) begin
          if (dur_inc == on_lat) begin
            dur_nxt   = '0;
            state_nxt = OFF;
            led_nxt   = 1'b0;
          end else begin
            dur_nxt = dur_inc;
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (dur_inc == off_lat) begin
            dur_nxt = '0;
            if (rem == CNT_W'(1)) begin
              rem_nxt   = '0;
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              rem_nxt   = rem - 1'b1;
              state_nxt = ON;
              led_nxt   = 1'b1;
            end
          end else begin
            dur_nxt = dur_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        led_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase

`ifdef BLINK_SEQ_ABORT_EN
    if (i_abort && (state != IDLE)) begin
      state_nxt = IDLE;
      dur_nxt   = '0;
      rem_nxt   = '0;
      led_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
`endif
  end

  assign o_led  = led;
  assign o_busy = busy;
  assign o_done = done;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer (CLK_TICKS=4): per-cycle expected {led,busy,done}
// is queued by the driver and compared by a negedge monitor.
module tb_blink_sequencer;

  localparam int CT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] on_ticks = '0;
  logic [7:0] off_ticks = '0;
  logic [3:0] count = '0;
`ifdef BLINK_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy, done, led;

  logic [31:0] cyc = '0;
  int checks = 0;
  int errors = 0;
  // entry: {cycle[31:0], led, busy, done}
  logic [34:0] exp_q[$];

  blink_sequencer #(.CLK_TICKS(CT), .DUR_W(8), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_on_ticks  (on_ticks),
    .i_off_ticks (off_ticks),
    .i_count     (count),
`ifdef BLINK_SEQ_ABORT_EN
    .i_abort     (abort),
`endif
    .o_busy      (busy),
    .o_done      (done),
    .o_led       (led)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0][34:3] == cyc) begin
        checks++;
        if ({led, busy, done} !== exp_q[0][2:0]) begin
          errors++;
          $display("FAIL outputs cyc=%0d led/busy/done got=%b want=%b",
                   cyc, {led, busy, done}, exp_q[0][2:0]);
        end
        void'(exp_q.pop_front());
      end else if (exp_q[0][34:3] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed cyc=%0d now=%0d got=%b want=%b",
                 exp_q[0][34:3], cyc, {led, busy, done}, exp_q[0][2:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic span(input int first, input int last, input logic [2:0] v);
    for (int c = first; c <= last; c++) exp_q.push_back({c[31:0], v});
  endtask

  // Expected trace of a full burst started at cycle t, plus an idle tail.
  task automatic exp_burst(input int t, input int on, input int off, input int cnt,
                           input int tail);
    int c;
    int on_e;
    int off_e;
    c     = t + 1;
    on_e  = (on == 0) ? 1 : on;
    off_e = (off == 0) ? 1 : off;
    for (int k = 0; k < cnt; k++) begin
      span(c, c + on_e * CT - 1, 3'b110);
      c += on_e * CT;
      span(c, c + off_e * CT - 1, 3'b010);
      c += off_e * CT;
    end
    span(c, c, 3'b001);
    c++;
    if (tail > 0) span(c, c + tail - 1, 3'b000);
  endtask

  // Advance to #1 after the posedge that makes cyc == c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_burst(input logic [7:0] on, input logic [7:0] off,
                             input logic [3:0] cnt, output int t);
    on_ticks  = on;
    off_ticks = off;
    count     = cnt;
    start     = 1'b1;
    t         = int'(cyc);
    @(posedge clk);
    #1;
    start     = 1'b0;
    on_ticks  = 8'hff;
    off_ticks = 8'hff;
    count     = 4'hf;
  endtask

  initial begin
    int t;
    int t2;
    int guard;
    // reset block
    span(1, 3, 3'b000);
    goto(3);
    rst = 1'b0;
    span(4, 6, 3'b000);
    goto(6);

    // on=2 off=3 count=2, literal timeline
    start_burst(8'd2, 8'd3, 4'd2, t);
    span(t + 1, t + 8, 3'b110);
    span(t + 9, t + 20, 3'b010);
    span(t + 21, t + 28, 3'b110);
    span(t + 29, t + 40, 3'b010);
    span(t + 41, t + 41, 3'b001);
    span(t + 42, t + 44, 3'b000);
    goto(t + 44);

    // count=0: done only
    start_burst(8'd5, 8'd5, 4'd0, t);
    exp_burst(t, 5, 5, 0, 3);
    goto(t + 4);

    // zero durations act as one tick
    start_burst(8'd0, 8'd0, 4'd1, t);
    exp_burst(t, 0, 0, 1, 3);
    goto(t + 12);

    // ignored mid-burst start, then back-to-back start on the done cycle
    start_burst(8'd2, 8'd3, 4'd2, t);
    exp_burst(t, 2, 3, 2, 0);
    goto(t + 10);
    start_burst(8'd1, 8'd1, 4'd1, t2);
    goto(t + 41);
    start_burst(8'd1, 8'd1, 4'd1, t2);
    exp_burst(t2, 1, 1, 1, 3);
    goto(t2 + 12);

    // reset during ON
    start_burst(8'd2, 8'd3, 4'd2, t);
    span(t + 1, t + 5, 3'b110);
    span(t + 6, t + 50, 3'b000);
    goto(t + 5);
    rst = 1'b1;
    goto(t + 6);
    rst = 1'b0;
    goto(t + 50);
    start_burst(8'd2, 8'd3, 4'd2, t);
    exp_burst(t, 2, 3, 2, 3);
    goto(t + 44);

`ifdef BLINK_SEQ_ABORT_EN
    // abort during OFF
    start_burst(8'd2, 8'd3, 4'd2, t);
    span(t + 1, t + 8, 3'b110);
    span(t + 9, t + 10, 3'b010);
    span(t + 11, t + 30, 3'b000);
    goto(t + 10);
    abort = 1'b1;
    goto(t + 11);
    abort = 1'b0;
    goto(t + 30);
    // abort in IDLE alongside start
    abort = 1'b1;
    start_burst(8'd1, 8'd2, 4'd1, t);
    abort = 1'b0;
    exp_burst(t, 1, 2, 1, 3);
    goto(t + 16);
`endif

    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout cyc=%0d pending=%0d", cyc, exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Sequences an LED blink burst: N on/off cycles with programmable on and off durations, measured in prescaled ticks.
- Sits between the control logic (button debounce or a command FSM) and the LED pin.
- Owns its own tick prescaler, which restarts on every burst start so the phase is deterministic.
- Start/busy/done handshake lets one requester chain bursts back to back.

Parameters:
- CLK_TICKS, 1000, i_clk cycles per tick; must be >= 2.
- DUR_W, 8, width of on/off duration fields (ticks).
- CNT_W, 4, width of burst repeat count.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_start  in  1  one-cycle start request; sampled only in IDLE.
- i_on_ticks  in  DUR_W  LED-on duration per blink, ticks.
- i_off_ticks  in  DUR_W  LED-off duration per blink, ticks.
- i_count  in  CNT_W  number of blinks in the burst.
- o_busy  out  1  high while a burst is in progress.
- o_done  out  1  one-cycle pulse at burst completion.
- o_led  out  1  LED drive, active-high.

Behaviour:
- Reset: state IDLE; o_busy=0, o_done=0, o_led=0; prescaler, duration counter and remaining count cleared. Reset wins over every other input in the same cycle, including mid-burst: the LED turns off and no o_done is issued.
- All outputs are registered.
- States: IDLE, ON, OFF.
- IDLE, i_start=1 at cycle T, i_count!=0:
  - Latch i_on_ticks, i_off_ticks and i_count; clear the prescaler.
  - From T+1: state ON, o_busy=1, o_led=1.
- IDLE, i_start=1 at cycle T, i_count==0: no blink; o_done=1 at T+1 only; o_busy stays 0.
- Duration of 0 in either field is treated as 1 tick.
- Prescaler: asserts an internal tick once every CLK_TICKS cycles. The first tick comes CLK_TICKS cycles after the start cycle; the period then repeats.
- ON: count ticks. When the count reaches the latched on value, move to OFF with o_led=0. ON lasts exactly on*CLK_TICKS cycles.
- OFF: count ticks. When the count reaches the latched off value, decrement the remaining count.
  - Remaining becomes 0: go to IDLE. In that same cycle o_busy falls and o_done pulses for one cycle.
  - Otherwise: go to ON with o_led=1.
  - OFF lasts exactly off*CLK_TICKS cycles.
- Total o_busy high time is count*(on+off)*CLK_TICKS cycles.
- i_start while o_busy=1 is ignored; it is not queued.
- Inputs are changeable while busy; only the latched copies are used.
- Back-to-back: i_start may be asserted in the cycle o_done is high (state already IDLE). The new burst's o_led rises the next cycle.
- Duration counters are DUR_W wide and never wrap; the compare is equality against the latched value.

Optional Feature:
- Macro BLINK_SEQ_ABORT_EN.
- Defined:
  - Extra port i_abort, in, 1.
  - i_abort=1 in ON or OFF: next cycle state IDLE, o_led=0, o_busy=0, o_done stays 0.
  - i_abort has priority over tick and phase transitions.
  - i_abort in IDLE has no effect, and i_start in the same cycle is still honoured.
- Undefined: port absent; bursts always run to completion.

Decomposition:
- Package blink_pkg holds:
  - the state enum typedef (IDLE, ON, OFF);
  - default width localparams DUR_W_DEF=8 and CNT_W_DEF=4.
- Sub-module tick_gen(CLK_TICKS):
  - ports i_clk, i_rst, i_clear, o_tick;
  - free-running 0..CLK_TICKS-1 counter;
  - o_tick high on the cycle the counter is at CLK_TICKS-1;
  - i_clear forces the count to 0.
- blink_sequencer instantiates tick_gen and drives i_clear from its start acceptance.

Test Plan (bench CLK_TICKS=4, DUR_W=8, CNT_W=4):
- Start at T with on=2, off=3, count=2 -> o_led high T+1..T+8, low T+9..T+20, high T+21..T+28, low T+29..T+40; o_busy low and o_done=1 at T+41 only.
- Start with count=0 -> o_done=1 at T+1 only; o_busy and o_led stay 0.
- on=0, off=0, count=1 -> o_led high 4 cycles, low 4 cycles; o_done at T+9.
- Second i_start mid-burst -> ignored, timing identical to the single burst; i_start on the o_done cycle -> new o_led rise the next cycle.
- i_rst during ON at T+5 -> next cycle o_led=0, o_busy=0, o_done never pulses; a fresh start afterwards behaves as in the first scenario.
- BLINK_SEQ_ABORT_EN: i_abort at T+10 (OFF) -> T+11 idle, o_led=0, o_busy=0, no o_done; i_abort in IDLE together with i_start -> burst starts normally.
